// File: rtl/adau1761_i2c_pkg.sv
// Shared opcodes, FSM state codes and bus-phase helpers for the ADAU1761 I2C sequencer.
// Imported by adau1761_i2c_sequencer and its phase timer.
package adau1761_i2c_pkg;

    typedef logic [2:0] fsm_state_t;

    localparam fsm_state_t ST_FETCH      = 3'd0;
    localparam fsm_state_t ST_WAIT_ROM   = 3'd1;
    localparam fsm_state_t ST_DECODE     = 3'd2;
    localparam fsm_state_t ST_EXEC_START = 3'd3;
    localparam fsm_state_t ST_EXEC_BIT   = 3'd4;
    localparam fsm_state_t ST_EXEC_ACK   = 3'd5;
    localparam fsm_state_t ST_EXEC_STOP  = 3'd6;
    localparam fsm_state_t ST_EXEC_DELAY = 3'd7;

    typedef enum logic [1:0] {
        QTR_0,
        QTR_1,
        QTR_2,
        QTR_3
    } quarter_t;

    localparam logic [7:0] OP_STOP     = 8'hFF;
    localparam logic [7:0] OP_DELAY    = 8'hFE;
    localparam logic [1:0] OP_JUMP     = 2'b00;
    localparam logic [3:0] OP_SKIP_CLR = 4'b1000;
    localparam logic [3:0] OP_SKIP_SET = 4'b1001;
    localparam logic [3:0] OP_CLR      = 4'b1010;
    localparam logic [3:0] OP_SET      = 4'b1011;

    function automatic logic is_bus_state(input fsm_state_t state);
        return (state == ST_EXEC_START) || (state == ST_EXEC_BIT) ||
               (state == ST_EXEC_ACK)   || (state == ST_EXEC_STOP);
    endfunction

    // Returns {scl, sda_t} for a quarter of a bus step; SDA only moves while SCL is
    // low except for the START fall and STOP rise.
    function automatic logic [1:0] bus_pins(input fsm_state_t state, input quarter_t q,
                                            input logic data_bit);
        logic scl_high;
        logic [1:0] pins;
        scl_high = (q == QTR_1) || (q == QTR_2);
        pins = 2'b11;
        case (state)
            ST_EXEC_START: begin
                case (q)
                    QTR_0:   pins = 2'b11;
                    QTR_3:   pins = 2'b00;
                    default: pins = 2'b10;
                endcase
            end
            ST_EXEC_BIT: pins = {scl_high, data_bit};
            ST_EXEC_ACK: pins = {scl_high, 1'b1};
            ST_EXEC_STOP: begin
                case (q)
                    QTR_0:   pins = 2'b00;
                    QTR_1:   pins = 2'b10;
                    default: pins = 2'b11;
                endcase
            end
            default: pins = 2'b11;
        endcase
        return pins;
    endfunction

endpackage

// File: rtl/adau1761_i2c_sequencer_phase_timer.sv
// Down-counter emitting a 1-clk tick every PERIOD clks while running; a load
// overrides the count so the same counter also times long DELAY instructions.
module i2c_phase_timer #(
    parameter int unsigned WIDTH  = 21,
    parameter int unsigned PERIOD = 250
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             run,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    output logic             tick
);

    localparam logic [WIDTH-1:0] RELOAD = WIDTH'(PERIOD - 1);

    logic [WIDTH-1:0] count;

    assign tick = run && (count == '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (run) begin
            if (count == '0) begin
                count <= RELOAD;
            end else begin
                count <= count - 1'b1;
            end
        end
    end

endmodule

// File: rtl/adau1761_i2c_sequencer.sv
// Fetch/decode engine running the ADAU1761 config ROM program as an open-drain I2C master.
// Optional macro ACK_RETRY_EN: on NACK, send STOP and replay the transaction from its opening WRITE.
module adau1761_i2c_sequencer #(
    parameter int unsigned CLK_DIV      = 250,
    parameter int unsigned DELAY_CYCLES = 2**20
) (
    input  logic        clk,
    input  logic        reset,
    output logic [9:0]  rom_address,
    input  logic [8:0]  rom_data,
    output logic        i2c_scl,
    input  logic        i2c_sda_i,
    output logic        i2c_sda_t,
    input  logic [15:0] inputs,
    output logic [15:0] outputs,
    output logic        busy,
    output logic        error
);

    import adau1761_i2c_pkg::*;

    localparam int unsigned MAX_LOAD = (DELAY_CYCLES > CLK_DIV) ? DELAY_CYCLES : CLK_DIV;
    localparam int unsigned TW       = $clog2(MAX_LOAD) + 1;
    localparam logic [TW-1:0] QTR_LOAD   = TW'(CLK_DIV - 1);
    localparam logic [TW-1:0] DELAY_LOAD = TW'(DELAY_CYCLES - 1);

    fsm_state_t  state, state_n;
    quarter_t    quarter, quarter_n;
    logic [9:0]  pc, pc_n;
    logic [9:0]  txn_pc, txn_pc_n;
    logic [7:0]  data, data_n;
    logic [2:0]  bit_idx, bit_idx_n;
    logic        busy_n, error_n;
    logic [15:0] flags_n;
    logic        retry_pend, retry_n;
    logic        ack_bit, ack_n;
    logic        scl_n, sda_n;
    logic        timer_run, timer_load, timer_tick;
    logic [TW-1:0] timer_value;
    logic [3:0]  idx;

    assign rom_address = pc;
    assign idx         = rom_data[3:0];
    assign timer_run   = is_bus_state(state) || (state == ST_EXEC_DELAY);

    i2c_phase_timer #(
        .WIDTH (TW),
        .PERIOD(CLK_DIV)
    ) u_timer (
        .clk       (clk),
        .reset     (reset),
        .run       (timer_run),
        .load      (timer_load),
        .load_value(timer_value),
        .tick      (timer_tick)
    );

    always_comb begin
        state_n     = state;
        quarter_n   = quarter;
        pc_n        = pc;
        txn_pc_n    = txn_pc;
        data_n      = data;
        bit_idx_n   = bit_idx;
        busy_n      = busy;
        error_n     = error;
        flags_n     = outputs;
        retry_n     = retry_pend;
        ack_n       = ack_bit;
        scl_n       = i2c_scl;
        sda_n       = i2c_sda_t;
        timer_load  = 1'b0;
        timer_value = QTR_LOAD;

        case (state)
            ST_FETCH:    state_n = ST_WAIT_ROM;
            ST_WAIT_ROM: state_n = ST_DECODE;
            ST_DECODE: begin
                state_n    = ST_FETCH;
                pc_n       = pc + 10'd1;
                quarter_n  = QTR_0;
                timer_load = 1'b1;
                if (rom_data[8]) begin
                    data_n    = rom_data[7:0];
                    bit_idx_n = 3'd7;
                    if (!busy) begin
                        state_n  = ST_EXEC_START;
                        busy_n   = 1'b1;
                        txn_pc_n = pc;
                    end else begin
                        state_n = ST_EXEC_BIT;
                    end
                end else if (rom_data[7:0] == OP_STOP) begin
                    if (busy) begin
                        state_n = ST_EXEC_STOP;
                    end
                end else if (rom_data[7:0] == OP_DELAY) begin
                    state_n     = ST_EXEC_DELAY;
                    timer_value = DELAY_LOAD;
                end else if (rom_data[7:6] == OP_JUMP) begin
                    pc_n = {1'b0, rom_data[5:0], 3'b000};
                end else begin
                    case (rom_data[7:4])
                        OP_SKIP_CLR: if (!inputs[idx]) pc_n = pc + 10'd2;
                        OP_SKIP_SET: if (inputs[idx])  pc_n = pc + 10'd2;
                        OP_CLR:      flags_n[idx] = 1'b0;
                        OP_SET:      flags_n[idx] = 1'b1;
                        default:     ;
                    endcase
                end
            end
            ST_EXEC_DELAY: begin
                if (timer_tick) begin
                    state_n = ST_FETCH;
                end
            end
            default: begin
                if (timer_tick) begin
                    if (quarter != QTR_3) begin
                        quarter_n = quarter_t'(quarter + 2'd1);
                        // End of the first SCL-high quarter is mid-high: sample ACK here.
                        if (state == ST_EXEC_ACK && quarter == QTR_1) begin
                            ack_n = i2c_sda_i;
                        end
                    end else begin
                        quarter_n = QTR_0;
                        case (state)
                            ST_EXEC_START: state_n = ST_EXEC_BIT;
                            ST_EXEC_BIT: begin
                                if (bit_idx == 3'd0) begin
                                    state_n = ST_EXEC_ACK;
                                end else begin
                                    bit_idx_n = bit_idx - 3'd1;
                                end
                            end
                            ST_EXEC_ACK: begin
                                state_n = ST_FETCH;
                                if (ack_bit) begin
                                    error_n = 1'b1;
`ifdef ACK_RETRY_EN
                                    state_n = ST_EXEC_STOP;
                                    retry_n = 1'b1;
`endif
                                end
                            end
                            default: begin
                                state_n = ST_FETCH;
                                busy_n  = 1'b0;
`ifdef ACK_RETRY_EN
                                if (retry_pend) begin
                                    pc_n    = txn_pc;
                                    retry_n = 1'b0;
                                end else begin
                                    error_n = 1'b0;
                                end
`endif
                            end
                        endcase
                    end
                end
            end
        endcase

        // Pins change only when a new quarter (or a new step) begins, otherwise they hold.
        if (is_bus_state(state_n) && (state_n != state || quarter_n != quarter)) begin
            {scl_n, sda_n} = bus_pins(state_n, quarter_n, data_n[bit_idx_n]);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_FETCH;
            quarter    <= QTR_0;
            pc         <= '0;
            txn_pc     <= '0;
            data       <= '0;
            bit_idx    <= '0;
            busy       <= 1'b0;
            error      <= 1'b0;
            outputs    <= '0;
            retry_pend <= 1'b0;
            ack_bit    <= 1'b0;
            i2c_scl    <= 1'b1;
            i2c_sda_t  <= 1'b1;
        end else begin
            state      <= state_n;
            quarter    <= quarter_n;
            pc         <= pc_n;
            txn_pc     <= txn_pc_n;
            data       <= data_n;
            bit_idx    <= bit_idx_n;
            busy       <= busy_n;
            error      <= error_n;
            outputs    <= flags_n;
            retry_pend <= retry_n;
            ack_bit    <= ack_n;
            i2c_scl    <= scl_n;
            i2c_sda_t  <= sda_n;
        end
    end

endmodule

// File: tb/tb_adau1761_i2c_sequencer.sv
// Self-checking bench: registered ROM, I2C codec listener with byte scoreboard,
// table of single-instruction vectors and hand sequences for bus and timing corners.
module tb_adau1761_i2c_sequencer;

    localparam int unsigned CLK_DIV      = 4;
    localparam int unsigned DELAY_CYCLES = 32;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [9:0]  rom_address;
    logic [8:0]  rom_data;
    logic        i2c_scl;
    logic        i2c_sda_i;
    logic        i2c_sda_t;
    logic [15:0] inputs;
    logic [15:0] outputs;
    logic        busy;
    logic        error;
    logic        ack_drive;

    logic [8:0]  rom [0:1023];

    always #5 clk = ~clk;

    always @(posedge clk) rom_data <= rom[rom_address];

    assign i2c_sda_i = i2c_sda_t & ~ack_drive;

    adau1761_i2c_sequencer #(
        .CLK_DIV     (CLK_DIV),
        .DELAY_CYCLES(DELAY_CYCLES)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .rom_address(rom_address),
        .rom_data   (rom_data),
        .i2c_scl    (i2c_scl),
        .i2c_sda_i  (i2c_sda_i),
        .i2c_sda_t  (i2c_sda_t),
        .inputs     (inputs),
        .outputs    (outputs),
        .busy       (busy),
        .error      (error)
    );

    int total = 0;
    int bad   = 0;

    logic [7:0] exp_q[$];
    bit         check_bytes;
    int         starts, stops, byte_cnt, txn_bytes, bitcnt, nack_budget, nack_at, busy_gap;
    bit         ack_phase, in_txn;
    logic       prev_scl, prev_sda;
    logic [7:0] shreg;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Codec model: decodes bytes off the wire, ACKs (or NACKs on request), counts START/STOP.
    initial begin
        ack_drive = 1'b0;
        forever begin
            @(negedge clk);
            if (reset) begin
                bitcnt = 0; ack_phase = 0; ack_drive = 1'b0; in_txn = 0;
                starts = 0; stops = 0; byte_cnt = 0; txn_bytes = 0;
                prev_scl = 1'b1; prev_sda = 1'b1; shreg = '0;
            end else begin
                if (prev_scl && i2c_scl && prev_sda && !i2c_sda_i) begin
                    starts++; bitcnt = 0; txn_bytes = 0; in_txn = 1; ack_phase = 0;
                end else if (prev_scl && i2c_scl && !prev_sda && i2c_sda_i) begin
                    stops++; in_txn = 0;
                end else if (!prev_scl && i2c_scl) begin
                    if (bitcnt < 8) begin
                        shreg = {shreg[6:0], i2c_sda_i};
                        bitcnt++;
                        if (bitcnt == 8) begin
                            byte_cnt++; txn_bytes++;
                            if (check_bytes) begin
                                if (exp_q.size() == 0) begin
                                    total++; bad++;
                                    $display("FAIL byte_unexpected: got 0x%0h expected none", shreg);
                                end else begin
                                    check("sda_byte", {24'd0, shreg}, {24'd0, exp_q.pop_front()});
                                end
                            end
                        end
                    end
                end else if (prev_scl && !i2c_scl) begin
                    if (ack_phase) begin
                        ack_drive = 1'b0; ack_phase = 0; bitcnt = 0;
                    end else if (bitcnt == 8) begin
                        ack_phase = 1;
                        if (nack_budget > 0 && txn_bytes == nack_at) begin
                            nack_budget--; ack_drive = 1'b0;
                        end else begin
                            ack_drive = 1'b1;
                        end
                    end
                end
                if (in_txn && !busy) busy_gap++;
                prev_scl = i2c_scl;
                prev_sda = i2c_sda_i;
            end
        end
    end

    task automatic clear_rom();
        for (int i = 0; i < 1024; i++) rom[i] = 9'h0EF;
    endtask

    task automatic enter_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic leave_reset();
        reset = 1'b0;
    endtask

    task automatic load_write_program();
        clear_rom();
        rom[0] = 9'h13B;
        rom[1] = 9'h140;
        rom[2] = 9'h0FF;
        rom[3] = 9'h001;
        rom[8] = 9'h001;
    endtask

    task automatic wait_stops(input int n, input string name);
        int c = 0;
        while (stops < n && c < 3000) begin
            @(negedge clk);
            c++;
        end
        check(name, stops, n);
    endtask

    typedef struct {
        string       name;
        logic [8:0]  instr;
        logic [15:0] in_flags;
        logic [9:0]  exp_addr;
        logic [15:0] exp_out;
    } vec_t;

    vec_t vecs[13];

    initial begin
        vecs[0]  = '{"nop",         9'h0EF, 16'h0000, 10'd1,   16'h0000};
        vecs[1]  = '{"other_nop",   9'h07F, 16'h0000, 10'd1,   16'h0000};
        vecs[2]  = '{"stop_idle",   9'h0FF, 16'h0000, 10'd1,   16'h0000};
        vecs[3]  = '{"skip0_taken", 9'h083, 16'hFFF7, 10'd2,   16'h0000};
        vecs[4]  = '{"skip0_not",   9'h083, 16'h0008, 10'd1,   16'h0000};
        vecs[5]  = '{"skip1_taken", 9'h093, 16'h0008, 10'd2,   16'h0000};
        vecs[6]  = '{"skip1_not",   9'h093, 16'hFFF7, 10'd1,   16'h0000};
        vecs[7]  = '{"skip0_i15",   9'h08F, 16'h7FFF, 10'd2,   16'h0000};
        vecs[8]  = '{"set2",        9'h0B2, 16'h0000, 10'd1,   16'h0004};
        vecs[9]  = '{"set15",       9'h0BF, 16'h0000, 10'd1,   16'h8000};
        vecs[10] = '{"jump5",       9'h005, 16'h0000, 10'd40,  16'h0000};
        vecs[11] = '{"jump63",      9'h03F, 16'h0000, 10'd504, 16'h0000};
        vecs[12] = '{"jump0",       9'h000, 16'h0000, 10'd0,   16'h0000};

        inputs = '0;
        check_bytes = 0;
        nack_budget = 0;
        nack_at = 0;
        busy_gap = 0;
        clear_rom();

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_addr",  {22'd0, rom_address}, 32'd0);
        check("rst_scl",   {31'd0, i2c_scl},   32'd1);
        check("rst_sda_t", {31'd0, i2c_sda_t}, 32'd1);
        check("rst_out",   {16'd0, outputs},   32'd0);
        check("rst_busy",  {31'd0, busy},      32'd0);
        check("rst_error", {31'd0, error},     32'd0);

        // Single-instruction table: one DECODE, 3 clks after reset release
        for (int v = 0; v < 13; v++) begin
            enter_reset();
            clear_rom();
            rom[0] = vecs[v].instr;
            inputs = vecs[v].in_flags;
            leave_reset();
            repeat (3) @(negedge clk);
            check({vecs[v].name, "_addr"}, {22'd0, rom_address}, {22'd0, vecs[v].exp_addr});
            check({vecs[v].name, "_out"},  {16'd0, outputs},     {16'd0, vecs[v].exp_out});
        end

        // SKIP then JUMP: address sequence
        for (int k = 0; k < 2; k++) begin
            enter_reset();
            clear_rom();
            rom[0] = 9'h083;
            rom[1] = 9'h005;
            inputs = (k == 0) ? 16'h0000 : 16'h0008;
            leave_reset();
            repeat (3) @(negedge clk);
            check("skipseq_a1", {22'd0, rom_address}, (k == 0) ? 32'd2 : 32'd1);
            repeat (3) @(negedge clk);
            check("skipseq_a2", {22'd0, rom_address}, (k == 0) ? 32'd3 : 32'd40);
        end
        inputs = '0;

        // SET then CLR timing
        enter_reset();
        clear_rom();
        rom[0] = 9'h0B2;
        rom[1] = 9'h0A2;
        leave_reset();
        repeat (3) @(negedge clk);
        check("setclr_rise", {16'd0, outputs}, 32'h4);
        repeat (2) @(negedge clk);
        check("setclr_hold", {16'd0, outputs}, 32'h4);
        @(negedge clk);
        check("setclr_fall", {16'd0, outputs}, 32'h0);

        // DELAY duration
        enter_reset();
        clear_rom();
        rom[0] = 9'h0FE;
        rom[1] = 9'h001;
        leave_reset();
        repeat (3) @(negedge clk);
        check("delay_pc1", {22'd0, rom_address}, 32'd1);
        repeat (DELAY_CYCLES + 2) @(negedge clk);
        check("delay_hold", {22'd0, rom_address}, 32'd1);
        @(negedge clk);
        check("delay_jump", {22'd0, rom_address}, 32'd8);

        // Fully ACKed two-byte write
        enter_reset();
        load_write_program();
        exp_q.delete();
        exp_q.push_back(8'h3B);
        exp_q.push_back(8'h40);
        check_bytes = 1;
        nack_budget = 0;
        busy_gap = 0;
        leave_reset();
        wait_stops(1, "ack_stop_seen");
        check("ack_starts", starts, 1);
        check("ack_bytes", byte_cnt, 2);
        check("ack_queue_empty", exp_q.size(), 0);
        check("ack_busy_gap", busy_gap, 0);
        check("ack_error", {31'd0, error}, 32'd0);
        repeat (4 * CLK_DIV + 2) @(negedge clk);
        check("ack_busy_clear", {31'd0, busy}, 32'd0);
        check("ack_scl_idle", {31'd0, i2c_scl}, 32'd1);
        check("ack_sda_idle", {31'd0, i2c_sda_t}, 32'd1);
        repeat (20) @(negedge clk);
        check("ack_pc_loop", {22'd0, rom_address}, 32'd8);

        // NACK on the second byte
        enter_reset();
        load_write_program();
        exp_q.delete();
        exp_q.push_back(8'h3B);
        exp_q.push_back(8'h40);
`ifdef ACK_RETRY_EN
        exp_q.push_back(8'h3B);
        exp_q.push_back(8'h40);
`endif
        nack_budget = 1;
        nack_at = 2;
        busy_gap = 0;
        leave_reset();
        begin
            int c = 0;
            while (byte_cnt < 2 && c < 3000) begin
                @(negedge clk);
                c++;
            end
            check("nack_byte2_seen", byte_cnt, 2);
            check("nack_error_before_ack", {31'd0, error}, 32'd0);
        end
        wait_stops(1, "nack_stop_seen");
        check("nack_error_set", {31'd0, error}, 32'd1);
        check("nack_busy_gap", busy_gap, 0);
`ifdef ACK_RETRY_EN
        wait_stops(2, "retry_stop_seen");
        repeat (4 * CLK_DIV + 2) @(negedge clk);
        check("retry_starts", starts, 2);
        check("retry_error_clear", {31'd0, error}, 32'd0);
`else
        repeat (40) @(negedge clk);
        check("nack_starts", starts, 1);
        check("nack_error_sticky", {31'd0, error}, 32'd1);
        check("nack_pc_proceeds", {22'd0, rom_address}, 32'd8);
`endif
        check("nack_queue_empty", exp_q.size(), 0);
        check("nack_busy_clear", {31'd0, busy}, 32'd0);

        // Reset pulsed in the middle of bit 5 of the first byte
        enter_reset();
        load_write_program();
        exp_q.delete();
        check_bytes = 0;
        nack_budget = 0;
        leave_reset();
        begin
            int c = 0;
            while (bitcnt < 2 && c < 3000) begin
                @(negedge clk);
                c++;
            end
            check("midbit_reached", bitcnt, 2);
        end
        repeat (3 * CLK_DIV + 1) @(negedge clk);
        check("midbit_pre_busy", {31'd0, busy}, 32'd1);
        check("midbit_pre_scl", {31'd0, i2c_scl}, 32'd0);
        reset = 1'b1;
        @(negedge clk);
        check("midbit_scl", {31'd0, i2c_scl}, 32'd1);
        check("midbit_sda_t", {31'd0, i2c_sda_t}, 32'd1);
        check("midbit_busy", {31'd0, busy}, 32'd0);
        check("midbit_addr", {22'd0, rom_address}, 32'd0);
        reset = 1'b0;
        repeat (5) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
